// File: rtl/seq_detect_sched_if.sv
// Bus between the serial channels / configuration master and the shared
// pattern-matching scheduler: handshake, config load and match reporting.
interface seq_detect_sched_if #(
    parameter int NCH = 4,
    parameter int PW  = 8,
    parameter int CW  = 8
);
    localparam int CHW = $clog2(NCH);

    logic            enable;
    logic            cfg_we;
    logic [PW-1:0]   cfg_pattern;
    logic [3:0]      cfg_len;
    logic            cfg_overlap;
    logic            cfg_busy;
    logic [NCH-1:0]  ch_valid;
    logic [NCH-1:0]  ch_bit;
    logic [NCH-1:0]  ch_ready;
    logic            match_valid;
    logic [CHW-1:0]  match_ch;
    logic [CW-1:0]   match_count;

    modport master (
        output enable, cfg_we, cfg_pattern, cfg_len, cfg_overlap, ch_valid, ch_bit,
        input  cfg_busy, ch_ready, match_valid, match_ch, match_count
    );

    modport slave (
        input  enable, cfg_we, cfg_pattern, cfg_len, cfg_overlap, ch_valid, ch_bit,
        output cfg_busy, ch_ready, match_valid, match_ch, match_count
    );
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one programmable serial pattern matcher among NCH channels.
// Optional feature macro: SEQ_DETECT_SCHED_COUNT_EN enables the saturating match counter.
module seq_detect_sched #(
    parameter int NCH = 4,
    parameter int PW  = 8,
    parameter int CW  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seq_detect_sched_if.slave bus
);
    localparam int CHW = $clog2(NCH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [3:0] LEN_RST = (PW < 3) ? 4'(PW) : 4'd3;

    logic [1:0]     r_state;
    logic [CHW-1:0] r_ptr;
    logic [CHW-1:0] r_clr_idx;
    logic [PW-1:0]  r_pat;
    logic [3:0]     r_len;
    logic           r_ovl;
    logic [PW-1:0]  r_hist [NCH];
    logic [3:0]     r_fill [NCH];
    logic           r_match_valid;
    logic [CHW-1:0] r_match_ch;

    logic           w_run;
    logic           w_found;
    logic [CHW-1:0] w_gidx;
    logic [CHW:0]   w_sum;
    logic [NCH-1:0] w_ready;
    logic           w_xfer;
    logic           w_bit;
    logic [PW-1:0]  w_new_hist;
    logic [PW-1:0]  w_mask;
    logic [4:0]     w_fill_inc;
    logic           w_full;
    logic [3:0]     w_new_fill;
    logic           w_hit;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len == 4'd0)
            return 4'd1;
        else if (32'(len) > PW)
            return 4'(PW);
        else
            return len;
    endfunction

    function automatic logic [PW-1:0] len_mask(input logic [3:0] len);
        logic [PW-1:0] m;
        m = '0;
        for (int i = 0; i < PW; i++)
            m[i] = (i < 32'(len));
        return m;
    endfunction

    // Circular first-valid search starting at the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_sum = {1'b0, r_ptr} + (CHW+1)'(k);
            if (w_sum >= (CHW+1)'(NCH))
                w_sum = w_sum - (CHW+1)'(NCH);
            if (!w_found && bus.ch_valid[w_sum[CHW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[CHW-1:0];
            end
        end
    end

    assign w_run      = (r_state == S_RUN);
    assign w_ready    = (w_found && w_run && !bus.cfg_we && bus.enable)
                        ? (NCH'(1) << w_gidx) : '0;
    assign w_xfer     = |(bus.ch_valid & w_ready);
    assign w_bit      = bus.ch_bit[w_gidx];
    assign w_new_hist = {r_hist[w_gidx][PW-2:0], w_bit};
    assign w_mask     = len_mask(r_len);
    assign w_fill_inc = {1'b0, r_fill[w_gidx]} + 5'd1;
    assign w_full     = (w_fill_inc >= {1'b0, r_len});
    assign w_new_fill = w_full ? r_len : w_fill_inc[3:0];
    assign w_hit      = w_xfer && w_full && ((w_new_hist & w_mask) == (r_pat & w_mask));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_clr_idx     <= '0;
            r_pat         <= '0;
            r_len         <= LEN_RST;
            r_ovl         <= 1'b0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
        end else begin
            if (bus.cfg_we) begin
                r_pat <= bus.cfg_pattern;
                r_len <= clamp_len(bus.cfg_len);
                r_ovl <= bus.cfg_overlap;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    if (!bus.enable)
                        r_state <= S_IDLE;
                    else if (bus.cfg_we)
                        r_clr_idx <= '0;
                    else if (r_clr_idx == CHW'(NCH-1))
                        r_state <= S_RUN;
                    else
                        r_clr_idx <= r_clr_idx + CHW'(1);
                end
                S_RUN: begin
                    if (!bus.enable)
                        r_state <= S_IDLE;
                    else if (bus.cfg_we) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_xfer)
                r_ptr <= (w_gidx == CHW'(NCH-1)) ? '0 : w_gidx + CHW'(1);
            r_match_valid <= w_hit;
            if (w_hit)
                r_match_ch <= w_gidx;
        end
    end

    // Per-channel history: CLEAR wipes one channel per cycle, RUN shifts in granted bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_hist[i] <= '0;
                r_fill[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (r_state == S_CLEAR && r_clr_idx == CHW'(i)) begin
                    r_hist[i] <= '0;
                    r_fill[i] <= '0;
                end else if (w_xfer && w_gidx == CHW'(i)) begin
                    r_hist[i] <= w_new_hist;
                    r_fill[i] <= (w_hit && !r_ovl) ? 4'd0 : w_new_fill;
                end
            end
        end
    end

`ifdef SEQ_DETECT_SCHED_COUNT_EN
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (w_hit && (r_count != {CW{1'b1}}))
            r_count <= r_count + CW'(1);
    end

    assign bus.match_count = r_count;
`else
    assign bus.match_count = '0;
`endif

    assign bus.cfg_busy    = (r_state == S_CLEAR);
    assign bus.ch_ready    = w_ready;
    assign bus.match_valid = r_match_valid;
    assign bus.match_ch    = r_match_ch;
endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based behavioural model.
module tb_seq_detect_sched;
    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int CW  = 8;
`ifdef SEQ_DETECT_SCHED_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_detect_sched_if #(.NCH(NCH), .PW(PW), .CW(CW)) bus ();

    seq_detect_sched #(.NCH(NCH), .PW(PW), .CW(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, per-channel bit queues, bits-since-last-match counters.
    int          m_state;
    int          m_ccnt;
    int          m_ptr;
    logic [PW-1:0] m_pat;
    int          m_len;
    bit          m_ovl;
    bit          m_mv;
    int          m_mch;
    int          m_count;
    int          m_bits [NCH][$];
    int          m_since [NCH];

    function automatic void m_reset();
        m_state = 0; m_ccnt = 0; m_ptr = 0;
        m_pat = '0; m_len = 3; m_ovl = 1'b0;
        m_mv = 1'b0; m_mch = 0; m_count = 0;
        for (int c = 0; c < NCH; c++) begin
            m_bits[c].delete();
            m_since[c] = 0;
        end
    endfunction

    function automatic bit tail_ok(input int g);
        int n;
        n = m_bits[g].size();
        for (int i = 0; i < m_len; i++)
            if (m_bits[g][n-1-i] != int'(m_pat[i])) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin : cmp
        int g;
        int idx;
        logic [NCH-1:0] er;
        if (!rst_n) begin
            m_reset();
            chk("rst_busy",   32'(bus.cfg_busy),    32'd0);
            chk("rst_ready",  32'(bus.ch_ready),    32'd0);
            chk("rst_mvalid", 32'(bus.match_valid), 32'd0);
            chk("rst_mcount", 32'(bus.match_count), 32'd0);
        end else begin
            g  = -1;
            er = '0;
            if (m_state == 2 && !bus.cfg_we && bus.enable)
                for (int k = 0; k < NCH; k++) begin
                    idx = (m_ptr + k) % NCH;
                    if (g < 0 && bus.ch_valid[idx]) g = idx;
                end
            if (g >= 0) er[g] = 1'b1;
            chk("busy",   32'(bus.cfg_busy),    32'(m_state == 1));
            chk("ready",  32'(bus.ch_ready),    32'(er));
            chk("mvalid", 32'(bus.match_valid), 32'(m_mv));
            if (m_mv) chk("mch", 32'(bus.match_ch), 32'(m_mch));
            chk("mcount", 32'(bus.match_count), 32'(m_count));

            m_mv = 1'b0;
            if (g >= 0) begin
                m_bits[g].push_back(int'(bus.ch_bit[g]));
                if (m_bits[g].size() > 16) void'(m_bits[g].pop_front());
                m_since[g]++;
                if (m_since[g] >= m_len && tail_ok(g)) begin
                    m_mv  = 1'b1;
                    m_mch = g;
                    if (CNT_EN && m_count < (1 << CW) - 1) m_count++;
                    if (!m_ovl) m_since[g] = 0;
                end
                m_ptr = (g + 1) % NCH;
            end
            case (m_state)
                0: if (bus.enable) begin m_state = 1; m_ccnt = 0; end
                1: begin
                    if (!bus.enable) m_state = 0;
                    else if (bus.cfg_we) m_ccnt = 0;
                    else if (m_ccnt == NCH - 1) begin
                        m_state = 2;
                        for (int c = 0; c < NCH; c++) begin
                            m_bits[c].delete();
                            m_since[c] = 0;
                        end
                    end else m_ccnt++;
                end
                default: begin
                    if (!bus.enable) m_state = 0;
                    else if (bus.cfg_we) begin m_state = 1; m_ccnt = 0; end
                end
            endcase
            if (bus.cfg_we) begin
                m_pat = bus.cfg_pattern;
                m_len = (bus.cfg_len == 0) ? 1 : ((int'(bus.cfg_len) > PW) ? PW : int'(bus.cfg_len));
                m_ovl = bus.cfg_overlap;
            end
        end
    end

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (bus.cfg_busy && n < 50) begin
            chk({name, "_rdy_in_clear"}, 32'(bus.ch_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_clear_cycles"}, 32'(n), 32'(NCH));
    endtask

    task automatic go_run(input string name);
        bus.enable = 1'b1;
        @(posedge clk); #1;
        wait_clear(name);
    endtask

    task automatic cfg(input string name, input logic [PW-1:0] p, input logic [3:0] l, input bit o);
        bus.cfg_we = 1'b1; bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = o;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        wait_clear(name);
    endtask

    task automatic send(input int ch, input bit b, output bit hit, output int mch);
        bus.ch_valid = NCH'(1) << ch;
        bus.ch_bit   = b ? '1 : '0;
        @(posedge clk); #1;
        hit = bus.match_valid;
        mch = int'(bus.match_ch);
        bus.ch_valid = '0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit h;
        int mc;
        logic [7:0] hv;
        logic [NCH-1:0] seq [5];
        int npulse;
        bus.enable = 0; bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = 4'd0;
        bus.cfg_overlap = 0; bus.ch_valid = '0; bus.ch_bit = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy",  32'(bus.cfg_busy),    32'd0);
        chk("init_ready", 32'(bus.ch_ready),    32'd0);
        chk("init_count", 32'(bus.match_count), 32'd0);
        rst_n = 1'b1;

        // Default config: three 0s, non-overlapping
        go_run("dflt");
        hv = '0;
        for (int i = 0; i < 6; i++) begin
            send(0, 1'b0, h, mc);
            hv[i] = h;
            if (h) chk("dflt_mch", 32'(mc), 32'd0);
        end
        chk("dflt_hits",  32'(hv), 32'b100100);
        chk("dflt_count", 32'(bus.match_count), CNT_EN ? 32'd2 : 32'd0);

        // Overlapping / non-overlapping 101
        cfg("ovl1", 8'b101, 4'd3, 1'b1);
        hv = '0;
        for (int i = 0; i < 5; i++) begin
            send(1, (i % 2) == 0, h, mc);
            hv[i] = h;
            if (h) chk("ovl1_mch", 32'(mc), 32'd1);
        end
        chk("ovl1_hits", 32'(hv), 32'b10100);
        cfg("ovl0", 8'b101, 4'd3, 1'b0);
        hv = '0;
        for (int i = 0; i < 5; i++) begin
            send(1, (i % 2) == 0, h, mc);
            hv[i] = h;
        end
        chk("ovl0_hits", 32'(hv), 32'b00100);

        // Mid-stream reconfiguration with a would-be transfer pending
        cfg("mid_a", 8'd0, 4'd3, 1'b0);
        send(0, 1'b0, h, mc);
        send(0, 1'b0, h, mc);
        bus.ch_valid = 4'b0001;
        bus.ch_bit   = '1;
        cfg("mid_b", 8'd0, 4'd3, 1'b0);
        bus.ch_valid = '0;
        hv = '0;
        for (int i = 0; i < 3; i++) begin
            send(0, 1'b0, h, mc);
            hv[i] = h;
        end
        chk("mid_hits", 32'(hv), 32'b100);

        // Async reset in the middle of CLEAR
        bus.cfg_we = 1'b1; bus.cfg_pattern = 8'b101; bus.cfg_len = 4'd5; bus.cfg_overlap = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        @(posedge clk); #1;
        bus.ch_valid = '1;
        bus.enable   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(bus.cfg_busy),    32'd0);
        chk("arst_ready",  32'(bus.ch_ready),    32'd0);
        chk("arst_mvalid", 32'(bus.match_valid), 32'd0);
        chk("arst_count",  32'(bus.match_count), 32'd0);
        #5;
        rst_n = 1'b1;
        bus.ch_valid = '0;
        @(posedge clk); #1;
        chk("arst_idle", 32'(bus.cfg_busy), 32'd0);

        // Round-robin with every channel requesting
        go_run("rr");
        bus.ch_valid = '1;
        bus.ch_bit   = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            seq[i] = bus.ch_ready;
            @(posedge clk); #1;
        end
        bus.ch_valid = '0;
        chk("rr0", 32'(seq[0]), 32'b0001);
        chk("rr1", 32'(seq[1]), 32'b0010);
        chk("rr2", 32'(seq[2]), 32'b0100);
        chk("rr3", 32'(seq[3]), 32'b1000);
        chk("rr4", 32'(seq[4]), 32'b0001);

        // Interleaved channels keep separate histories
        hv = '0;
        for (int i = 0; i < 5; i++) begin
            send((i % 2 == 0) ? 1 : 2, 1'b0, h, mc);
            hv[i] = h;
            if (h) chk("ilv_mch", 32'(mc), 32'd1);
        end
        chk("ilv_hits", 32'(hv), 32'b10000);
        hv = '0;
        for (int i = 0; i < 3; i++) begin
            send(0, 1'b0, h, mc);
            hv[i] = h;
        end
        chk("post_rst_hits",  32'(hv), 32'b100);
        chk("post_rst_count", 32'(bus.match_count), CNT_EN ? 32'd2 : 32'd0);

        // Counter saturation: 300 default matches on channel 0
        npulse = 0;
        for (int i = 0; i < 900; i++) begin
            send(0, 1'b0, h, mc);
            if (h) npulse++;
        end
        chk("sat_last_pulse", 32'(h), 32'd1);
        chk("sat_pulses", 32'(npulse), 32'd300);
        chk("sat_count", 32'(bus.match_count), CNT_EN ? 32'd255 : 32'd0);

        // Randomized traffic, enable drops and reconfigurations
        for (int i = 0; i < 3000; i++) begin
            bus.enable      = ($urandom_range(0, 99) != 0);
            bus.cfg_we      = ($urandom_range(0, 149) == 0);
            bus.cfg_pattern = PW'($urandom_range(0, 3));
            bus.cfg_len     = 4'($urandom_range(0, 15));
            bus.cfg_overlap = 1'($urandom_range(0, 1));
            bus.ch_valid    = NCH'($urandom);
            bus.ch_bit      = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            @(posedge clk); #1;
        end
        bus.cfg_we = 1'b0;
        bus.ch_valid = '0;
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler and configuration controller that shares one programmable serial pattern-matching engine among NCH serial input channels. It grants one channel bit per cycle and keeps per-channel match history. It also holds the programmable pattern, length and overlap mode, and reports each detection with the channel number. It sits between the serial front-end channels and the event-logging logic, replacing per-channel hard-wired sequence detectors.

## Interface
- NCH, 4: number of serial channels, 2..8
- PW, 8: maximum pattern width in bits, 2..15
- CW, 8: match counter width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = run scheduling, 0 = go idle
- cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  in  PW  pattern; bit 0 = most recent bit
- cfg_len  in  4  pattern length
- cfg_overlap  in  1  1 = overlapping detection
- cfg_busy  out  1  high while histories are being cleared
- ch_valid  in  NCH  channel i presents a bit
- ch_bit  in  NCH  channel i data bit
- ch_ready  out  NCH  one-hot grant (combinational)
- match_valid  out  1  registered one-cycle detection pulse
- match_ch  out  clog2(NCH)  channel of the detection
- match_count  out  CW  total detections, saturating

## Operation
- Reset values:
  - state IDLE; rr pointer 0; all histories/fill counters 0.
  - Config is pattern 0, len 3, overlap 0, so the default function is "three 0s, non-overlapping".
  - Outputs cfg_busy, ch_ready, match_valid, match_ch and match_count are all 0.
- States:
  - IDLE: ch_ready=0. Goes to CLEAR when enable=1.
  - CLEAR: runs for NCH cycles and zeroes one channel's history and fill per cycle; cfg_busy=1, ch_ready=0. Goes to RUN after the last channel, or to IDLE if enable=0.
  - RUN: arbitrate and match. Goes to IDLE if enable=0.
- Configuration:
  - cfg_we is latched in any state.
  - In RUN or CLEAR, cfg_we also (re)starts CLEAR from channel 0.
  - In IDLE, cfg_we only latches.
- cfg_len clamping: cfg_len=0 is treated as 1; cfg_len>PW is treated as PW.
- Arbitration (RUN only):
  - The grant goes to the first channel with ch_valid=1, searching circularly from the pointer.
  - ch_ready = grant & RUN & ~cfg_we & enable.
  - A transfer occurs when ch_valid&ch_ready; the pointer then becomes granted index+1, mod NCH.
  - The pointer is unchanged when there is no transfer.
- Per-channel update on a transfer of channel g:
  - hist[g] shifts left with the new bit in at bit 0.
  - fill[g] increments, saturating at len.
- Match condition: (fill[g]+1 ≥ len) and the low len bits of the new hist[g] equal the low len bits of the pattern.
- On a match:
  - match_valid=1 and match_ch=g; match_count increments, saturating at all-ones.
  - If overlap=0, fill[g] is cleared to 0.
  - If overlap=1, fill[g] stays saturated.
- enable=0 in RUN: in-flight history is discarded, since re-entry always passes through CLEAR.

## Timing
- Match latency: a bit transferred at edge k produces match_valid high from edge k until edge k+1, with match_ch valid in the same window.
- match_valid never stays high two cycles unless there are matches on consecutive transfers.
- Throughput: one bit per cycle total across all channels. With all channels valid, each channel is served every NCH cycles.
- CLEAR takes exactly NCH cycles; cfg_busy falls at the edge entering RUN. The first grant is possible in the first RUN cycle.
- cfg_we asserted in the same cycle as a would-be transfer: no transfer happens (ch_ready forced 0), and CLEAR starts at the next edge.
- reset asserted at any time: all outputs go 0 immediately (asynchronously), and the config returns to its defaults.
- match_count at all-ones: stays all-ones; match_valid still pulses.

## Configuration
- SEQ_DETECT_SCHED_COUNT_EN
  - Defined: the match_count register is implemented as described.
  - Undefined: no counter; match_count is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Default config after reset: enable=1, wait 4 cycles of CLEAR, then ch0 sends six 0s back-to-back. Required: match_valid on the 3rd and 6th transfers, match_ch=0, match_count=2.
- Overlap: pattern=3'b101, len=3, overlap=1, ch1 sends 1,0,1,0,1. Required: matches on transfers 3 and 5. With overlap=0 the same stream gives a match on transfer 3 only.
- Round-robin: all ch_valid=1 continuously. Required: ch_ready sequence 0001,0010,0100,1000,0001. With ch1/ch2 bits interleaved, histories stay independent and no cross-channel match occurs.
- Mid-stream config: ch0 sends 0,0, then cfg_we with the same defaults. Required: cfg_busy high 4 cycles, no ch_ready; after RUN, one further 0 gives no match and a third 0 gives a match.
- Async reset during CLEAR: reset low for half a cycle. Required: cfg_busy, ch_ready and match_count are 0 before the next edge; state IDLE; config back to defaults.
- Saturation (macro defined, CW=8): 300 default matches. Required: match_count=255 and match_valid keeps pulsing. With the macro undefined, match_count=0 throughout.
